// File: rtl/pda_fir_pkg.sv
//==============================================================================
// Module      : pda_fir_pkg
// Description : Shared widths, settle default and capture FSM states for the
//               PDA FIR datapath and its Yn capture FIFO.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pda_fir_pkg;

    localparam int YN_W          = 16;
    localparam int X_W           = 8;
    localparam int SETTLE_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2
    } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/yn_sync_fifo.sv
//==============================================================================
// Module      : yn_sync_fifo
// Description : Show-ahead synchronous FIFO with push/pop arbitration; a push
//               into a full FIFO is accepted only when a pop frees a slot.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module yn_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_req,
    input  logic signed [WIDTH-1:0]    wr_data,
    output logic                       wr_accept,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic signed [WIDTH-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic signed [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    full;
    logic                    pop;

    assign full      = (count == CW'(DEPTH));
    assign rd_valid  = (count != '0);
    assign pop       = rd_valid && rd_ready;
    assign wr_accept = wr_req && (!full || pop);
    // Zero when empty so the read port is clean out of reset.
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
            case ({wr_accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_accept) mem[wr_ptr] <= wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/yn_capture_fifo.sv
//==============================================================================
// Module      : yn_capture_fifo
// Description : Captures FIR output Yn a fixed settle time after each sample
//               strobe into a FIFO with sticky overflow/late flags.
//               Optional build macro YN_PEAK_EN adds a max-|Yn| tracker.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module yn_capture_fifo
    import pda_fir_pkg::*;
#(
    parameter int YN_W          = pda_fir_pkg::YN_W,
    parameter int DEPTH         = 16,
    parameter int SETTLE_CYCLES = pda_fir_pkg::SETTLE_CYCLES,
    parameter int CNT_W         = 4
) (
    input  logic                      clk,
    input  logic                      Rst,
    input  logic                      sample_stb,
    input  logic signed [YN_W-1:0]    Yn,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic signed [YN_W-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      ovf,
    output logic                      late,
    input  logic                      clr_flags,
    output logic [YN_W-1:0]           peak_abs
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    cap_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             capture;
    logic             late_set;
    logic             wr_accept;

    always_ff @(posedge clk) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        capture  = 1'b0;
        late_set = 1'b0;
        case (state)
            IDLE: begin
                if (sample_stb) begin
                    state_n = WAIT;
                    cnt_n   = RELOAD;
                end
            end
            WAIT: begin
                // A strobe while settling restarts the timer; the newest sample wins.
                if (sample_stb) begin
                    late_set = 1'b1;
                    cnt_n    = RELOAD;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = CAPT;
                end
            end
            CAPT: begin
                capture = 1'b1;
                if (sample_stb) begin
                    state_n = WAIT;
                    cnt_n   = RELOAD;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    yn_sync_fifo #(
        .WIDTH (YN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (Rst),
        .wr_req    (capture),
        .wr_data   (Yn),
        .wr_accept (wr_accept),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (Rst) begin
            ovf  <= 1'b0;
            late <= 1'b0;
        end else begin
            if (capture && !wr_accept) ovf <= 1'b1;
            else if (clr_flags)        ovf <= 1'b0;
            if (late_set)              late <= 1'b1;
            else if (clr_flags)        late <= 1'b0;
        end
    end

`ifdef YN_PEAK_EN
    logic [YN_W-1:0] yn_abs;
    logic [YN_W-1:0] peak_q;
    logic [YN_W-1:0] peak_base;

    // The most negative code has no positive twin; saturate it.
    always_comb begin
        if (Yn[YN_W-1] && (Yn[YN_W-2:0] == '0))
            yn_abs = {1'b0, {(YN_W-1){1'b1}}};
        else if (Yn[YN_W-1])
            yn_abs = YN_W'(-Yn);
        else
            yn_abs = YN_W'(Yn);
        peak_base = clr_flags ? '0 : peak_q;
    end

    always_ff @(posedge clk) begin
        if (Rst)
            peak_q <= '0;
        else if (wr_accept)
            peak_q <= (yn_abs > peak_base) ? yn_abs : peak_base;
        else if (clr_flags)
            peak_q <= '0;
    end

    assign peak_abs = peak_q;
`else
    assign peak_abs = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_yn_capture_fifo.sv
//==============================================================================
// Module      : tb_yn_capture_fifo
// Description : Self-checking scoreboard bench for yn_capture_fifo.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_yn_capture_fifo;

    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               Rst = 1'b1;
    logic               sample_stb = 1'b0;
    logic signed [15:0] Yn = '0;
    logic               rd_valid;
    logic               rd_ready = 1'b0;
    logic signed [15:0] rd_data;
    logic [4:0]         count;
    logic               ovf;
    logic               late;
    logic               clr_flags = 1'b0;
    logic [15:0]        peak_abs;

    int vectors = 0;
    int miscompares = 0;
    logic signed [15:0] sb [$];

    always #5 clk = ~clk;

    yn_capture_fifo #(
        .YN_W          (16),
        .DEPTH         (DEPTH),
        .SETTLE_CYCLES (3),
        .CNT_W         (4)
    ) dut (
        .clk        (clk),
        .Rst        (Rst),
        .sample_stb (sample_stb),
        .Yn         (Yn),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .count      (count),
        .ovf        (ovf),
        .late       (late),
        .clr_flags  (clr_flags),
        .peak_abs   (peak_abs)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe once and wait through the capture edge (stb edge + 4).
    task automatic capture(input logic signed [15:0] v, input bit expect_store);
        Yn = v;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        repeat (4) tick();
        if (expect_store) sb.push_back(v);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            logic signed [15:0] exp_v;
            exp_v = sb.pop_front();
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
                miscompares++;
                $display("FAIL %s drain[%0d]: got valid=%b data=%h, want valid=1 data=%h",
                         name, i, rd_valid, rd_data, exp_v);
            end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        vectors++;
        if (rd_valid !== 1'b0 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL %s empty: got valid=%b count=%0d, want 0/0", name, rd_valid, count);
        end
        sb.delete();
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({rd_valid, count, ovf, late, peak_abs, rd_data} !== '0) begin
            miscompares++;
            $display("FAIL reset: got valid=%b count=%0d ovf=%b late=%b peak=%h data=%h, want all 0",
                     rd_valid, count, ovf, late, peak_abs, rd_data);
        end
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        Yn = 16'sh1234;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        repeat (3) tick();
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: got valid=%b, want 0", rd_valid);
        end
        tick();
        sb.push_back(16'sh1234);
        vectors++;
        if (rd_valid !== 1'b1 || count !== 5'd1) begin
            miscompares++;
            $display("FAIL latency_on_time: got valid=%b count=%0d, want 1/1", rd_valid, count);
        end
        drain("latency");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) capture(16'(i * 97 - 700), 1'b1);
        vectors++;
        if (count !== 5'd16 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_full: got count=%0d ovf=%b, want 16/0", count, ovf);
        end
        capture(16'sh7abc, 1'b0);
        vectors++;
        if (count !== 5'd16 || ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_17th: got count=%0d ovf=%b, want 16/1", count, ovf);
        end
        drain("overflow");
        clear_flags();
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: got ovf=%b, want 0", ovf);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < DEPTH; i++) capture(16'(-(i * 311) + 5), 1'b1);
        Yn = 16'sh5a5a;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        repeat (3) tick();
        rd_ready = 1'b1;
        begin
            logic signed [15:0] head;
            head = sb.pop_front();
            vectors++;
            if (rd_data !== head) begin
                miscompares++;
                $display("FAIL fullpop_head: got %h, want %h", rd_data, head);
            end
        end
        tick();
        rd_ready = 1'b0;
        sb.push_back(16'sh5a5a);
        vectors++;
        if (count !== 5'd16 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL fullpop_count: got count=%0d ovf=%b, want 16/0", count, ovf);
        end
        drain("fullpop");
    endtask

    task automatic test_late();
        Yn = 16'sh0111;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        tick();
        Yn = -16'sd2222;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        vectors++;
        if (late !== 1'b1) begin
            miscompares++;
            $display("FAIL late_flag: got %b, want 1", late);
        end
        repeat (3) tick();
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL late_nocapt5: got valid=%b, want 0", rd_valid);
        end
        tick();
        sb.push_back(-16'sd2222);
        vectors++;
        if (count !== 5'd1) begin
            miscompares++;
            $display("FAIL late_capt6: got count=%0d, want 1", count);
        end
        repeat (3) tick();
        vectors++;
        if (count !== 5'd1) begin
            miscompares++;
            $display("FAIL late_single: got count=%0d, want 1", count);
        end
        drain("late");
        clear_flags();
        vectors++;
        if (late !== 1'b0) begin
            miscompares++;
            $display("FAIL late_clear: got %b, want 0", late);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) capture(16'(i + 40), 1'b0);
        Yn = 16'sh0999;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        vectors++;
        if (count !== 5'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid: got count=%0d valid=%b, want 0/0", count, rd_valid);
        end
        repeat (6) tick();
        vectors++;
        if (count !== 5'd0) begin
            miscompares++;
            $display("FAIL rstmid_nocapt: got count=%0d, want 0", count);
        end
    endtask

    task automatic test_peak();
        logic signed [15:0] vals [3];
        logic [15:0]        exp_pk [3];
        vals = '{-16'sd300, 16'sd1200, -16'sd32768};
`ifdef YN_PEAK_EN
        exp_pk = '{16'd300, 16'd1200, 16'd32767};
`else
        exp_pk = '{16'd0, 16'd0, 16'd0};
`endif
        for (int i = 0; i < 3; i++) begin
            capture(vals[i], 1'b1);
            vectors++;
            if (peak_abs !== exp_pk[i]) begin
                miscompares++;
                $display("FAIL peak[%0d]: got %0d, want %0d", i, peak_abs, exp_pk[i]);
            end
        end
        drain("peak");
        clear_flags();
        vectors++;
        if (peak_abs !== 16'd0) begin
            miscompares++;
            $display("FAIL peak_clear: got %0d, want 0", peak_abs);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_full_pop();
        test_late();
        test_reset_mid();
        test_peak();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
